// File: rtl/carpark_pkg.sv
// Shared definitions for the car park entry gate: FSM encodings and default sizing.
// Also imported by the lane sensor FSM bench.
package carpark_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } state_e;

  localparam int CAPACITY_DEF = 8;
  localparam int TIMEOUT_DEF  = 100;
  localparam int GUARD_DEF    = 4;

endpackage

// File: rtl/carpark_gate_ctrl_occupancy_counter.sv
// Saturating up/down occupancy counter with full/empty decode and a registered
// error pulse for an enter at full or an exit at empty.
module occupancy_counter #(
  parameter  int CAPACITY = 8,
  localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  assign full_o  = (count_q == CNT_W'(CAPACITY));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign err_o   = err_q;

  // Simultaneous enter and exit cancel out and are never an error.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (inc_i && !dec_i) begin
      if (full_o) err_d   = 1'b1;
      else        count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (empty_o) err_d   = 1'b1;
      else         count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/carpark_gate_ctrl.sv
// Entry barrier sequencer and occupancy tracker for the car park.
// Define CARPARK_STATS_EN to add the wrapping total_entries counter port.
module carpark_gate_ctrl
  import carpark_pkg::*;
#(
  parameter  int CAPACITY = CAPACITY_DEF,
  parameter  int TIMEOUT  = TIMEOUT_DEF,
  parameter  int GUARD    = GUARD_DEF,
  localparam int CNT_W    = $clog2(CAPACITY + 1),
  localparam int TMR_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_waiting,
  input  logic             enter,
  input  logic             exit,
  output logic             barrier_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             deny,
  output logic             timeout,
  output logic             err
`ifdef CARPARK_STATS_EN
  ,
  output logic [15:0]      total_entries
`endif
);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             barrier_q;
  logic             timeout_q, timeout_d;
  logic             deny_q, deny_d;
  logic             deny_cond, deny_cond_q;

  occupancy_counter #(.CAPACITY(CAPACITY)) u_occ (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (enter),
    .dec_i   (exit),
    .count_o (occupancy),
    .full_o  (full),
    .empty_o (empty),
    .err_o   (err)
  );

  // Deny only fires on the rising edge of a blocked request, not every cycle.
  assign deny_cond = (state_q == ST_IDLE) && car_waiting && full;
  assign deny_d    = deny_cond && !deny_cond_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (car_waiting && !full) begin
          state_d = ST_OPEN;
          timer_d = '0;
        end
      end
      ST_OPEN: begin
        if (enter) begin
          state_d = ST_CLOSE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = ST_CLOSE;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_CLOSE: begin
        if (timer_q == TMR_W'(GUARD - 1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      barrier_q   <= 1'b0;
      timeout_q   <= 1'b0;
      deny_q      <= 1'b0;
      deny_cond_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      barrier_q   <= (state_d == ST_OPEN);
      timeout_q   <= timeout_d;
      deny_q      <= deny_d;
      deny_cond_q <= deny_cond;
    end
  end

  assign barrier_open = barrier_q;
  assign timeout      = timeout_q;
  assign deny         = deny_q;

`ifdef CARPARK_STATS_EN
  logic [15:0] entries_q;

  // Mirrors the counter's accept condition so rejected enters are not tallied.
  always_ff @(posedge clk) begin
    if (rst)                           entries_q <= 16'd0;
    else if (enter && !exit && !full)  entries_q <= entries_q + 16'd1;
  end

  assign total_entries = entries_q;
`endif

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Self-checking bench for carpark_gate_ctrl: vector table plus multi-cycle sequences.
module tb_carpark_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cw = 1'b0, en = 1'b0, ex = 1'b0;
  logic       barrier_open, full, empty, deny, timeout, err;
  logic [3:0] occupancy;
`ifdef CARPARK_STATS_EN
  logic [15:0] total_entries;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  carpark_gate_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .car_waiting  (cw),
    .enter        (en),
    .exit         (ex),
    .barrier_open (barrier_open),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .deny         (deny),
    .timeout      (timeout),
    .err          (err)
`ifdef CARPARK_STATS_EN
    ,
    .total_entries(total_entries)
`endif
  );

  typedef struct {
    string name;
    bit    r, cw, en, ex;
    bit    bar;
    int    occ;
    bit    dn, tmo, er;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(string n, bit r, bit c, bit e, bit x,
                              bit bar, int occ, bit dn, bit tmo, bit er);
    vec_t v;
    v.name = n; v.r = r; v.cw = c; v.en = e; v.ex = x;
    v.bar = bar; v.occ = occ; v.dn = dn; v.tmo = tmo; v.er = er;
    return v;
  endfunction

  task automatic check();
    vec_t e;
    bit   ef, ee;
    e  = sb.pop_front();
    ef = (e.occ == 8);
    ee = (e.occ == 0);
    n_tests++;
    if (barrier_open !== e.bar || occupancy !== 4'(e.occ) || full !== ef ||
        empty !== ee || deny !== e.dn || timeout !== e.tmo || err !== e.er) begin
      n_fail++;
      $display("FAIL %s: got bar=%0b occ=%0d full=%0b empty=%0b deny=%0b tmo=%0b err=%0b, want bar=%0b occ=%0d full=%0b empty=%0b deny=%0b tmo=%0b err=%0b",
               e.name, barrier_open, occupancy, full, empty, deny, timeout, err,
               e.bar, e.occ, ef, ee, e.dn, e.tmo, e.er);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.r; cw = v.cw; en = v.en; ex = v.ex;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    // reset with all inputs active: outputs must stay cleared
    for (int i = 0; i < 3; i++) vecs.push_back(mk("reset", 1, 1, 1, 1, 0, 0, 0, 0, 0));
    // open on empty park, enter, guard of 4 cycles, reopen
    vecs.push_back(mk("open_empty",  0, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("enter_close", 0, 1, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk("guard_hold", 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("reopen",      0, 1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("enter2",      0, 0, 1, 0, 0, 2, 0, 0, 0));
    // tailgating enters fill the park
    for (int i = 3; i <= 8; i++) vecs.push_back(mk("fill", 0, 0, 1, 0, 0, i, 0, 0, 0));
    // waiting at full: one deny pulse in ten cycles, barrier stays down
    vecs.push_back(mk("deny_pulse", 0, 1, 0, 0, 0, 8, 1, 0, 0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk("deny_once", 0, 1, 0, 0, 0, 8, 0, 0, 0));
    vecs.push_back(mk("enter_at_full", 0, 0, 1, 0, 0, 8, 0, 0, 1));
    vecs.push_back(mk("err_clears",    0, 0, 0, 0, 0, 8, 0, 0, 0));
    vecs.push_back(mk("both_at_full",  0, 0, 1, 1, 0, 8, 0, 0, 0));
    for (int i = 7; i >= 3; i--) vecs.push_back(mk("exit", 0, 0, 0, 1, 0, i, 0, 0, 0));
    vecs.push_back(mk("both_at_3",     0, 0, 1, 1, 0, 3, 0, 0, 0));
    for (int i = 2; i >= 0; i--) vecs.push_back(mk("exit", 0, 0, 0, 1, 0, i, 0, 0, 0));
    vecs.push_back(mk("exit_at_empty", 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("err_clears2",   0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // barrier open with no enter: down with timeout pulse on the 100th cycle
    apply(mk("tmo_open", 0, 1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k < 100; k++) apply(mk("tmo_wait", 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("tmo_fire", 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) apply(mk("tmo_guard", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // enter on the final open cycle beats the timeout
    apply(mk("late_open", 0, 1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k < 100; k++) apply(mk("late_wait", 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("late_enter", 0, 0, 1, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) apply(mk("late_guard", 0, 0, 0, 0, 0, 1, 0, 0, 0));

    // reset while open drops barrier and clears occupancy on the next edge
    apply(mk("rst_open",  0, 1, 0, 0, 1, 1, 0, 0, 0));
    apply(mk("rst_mid",   1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef CARPARK_STATS_EN
    for (int i = 1; i <= 5; i++) apply(mk("stats_enter", 0, 0, 1, 0, 0, i, 0, 0, 0));
    n_tests++;
    if (total_entries !== 16'd5) begin
      n_fail++;
      $display("FAIL total_entries: got %0d, want 5", total_entries);
    end
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
